// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand fetch stage and the functional unit it feeds.
// Holds widths, function-select opcodes, instruction field positions and a decode helper.
// No logic state lives here; everything is constants, types and pure functions.
package operand_fetch_stage_pkg;

   localparam int DATA_W = 16;
   localparam int REG_N  = 8;
   localparam int ADDR_W = 3;
   localparam int FS_W   = 3;

   // Function-select opcodes, identical encoding to the functional unit.
   typedef enum logic [FS_W-1:0] {
      FS_ADD = 3'b000,
      FS_SUB = 3'b001,
      FS_AND = 3'b010,
      FS_OR  = 3'b011,
      FS_XOR = 3'b100,
      FS_NOT = 3'b101,
      FS_SLA = 3'b110,
      FS_SRA = 3'b111
   } fs_e;

   // Instruction field bit positions; bits [3:0] are ignored.
   localparam int FS_MSB = 15;
   localparam int FS_LSB = 13;
   localparam int RD_MSB = 12;
   localparam int RD_LSB = 10;
   localparam int RS_MSB = 9;
   localparam int RS_LSB = 7;
   localparam int RT_MSB = 6;
   localparam int RT_LSB = 4;

   // Binary ops (ADD..XOR) read rt; NOT and the shifts do not.
   function automatic logic uses_rt(input logic [FS_W-1:0] fs);
      return (fs <= FS_XOR);
   endfunction

endpackage

// File: rtl/operand_fetch_stage_regfile.sv
// 8x16 register file: one synchronous write port, two combinational read ports.
// Latency: reads are combinational, writes land on the next clock edge.
// Backpressure: none; the same-cycle write-back value is bypassed onto the read ports.
module regfile_8x16
   import operand_fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en_i,
   input  logic [ADDR_W-1:0] wb_addr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic [ADDR_W-1:0] ra_a_i,
   input  logic [ADDR_W-1:0] ra_b_i,
   output logic [DATA_W-1:0] rd_a_o,
   output logic [DATA_W-1:0] rd_b_o
);

   logic [DATA_W-1:0] regs_q [REG_N];

   // Write port: r0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
      end else if (wb_en_i && (wb_addr_i != '0)) begin
         regs_q[wb_addr_i] <= wb_data_i;
      end
   end

   // Read ports: r0 forced to zero, otherwise a matching write-back wins over the array.
   assign rd_a_o = (ra_a_i == '0)                      ? '0        :
                   (wb_en_i && (wb_addr_i == ra_a_i)) ? wb_data_i : regs_q[ra_a_i];
   assign rd_b_o = (ra_b_i == '0)                      ? '0        :
                   (wb_en_i && (wb_addr_i == ra_b_i)) ? wb_data_i : regs_q[ra_b_i];

endmodule

// File: rtl/operand_fetch_stage.sv
// Issue stage: decodes an instruction, reads operands with bypass, blocks RAW hazards.
// Latency: 1 cycle from accept to out_valid; 1 instruction per cycle when unblocked.
// Backpressure: output register holds while out_valid && !out_ready; instr_ready drops.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] inS,
   output logic [DATA_W-1:0] inT,
   output logic [FS_W-1:0]   FS,
   output logic [ADDR_W-1:0] rd_out
);

   logic [FS_W-1:0]   dec_fs;
   logic [ADDR_W-1:0] dec_rd, dec_rs, dec_rt;
   logic              rt_used;
   logic [DATA_W-1:0] op_s, op_t;
   logic              hz_s, hz_t, hazard, slot_free, accept;

   logic              out_valid_q;
   logic [DATA_W-1:0] ins_q, int_q;
   logic [FS_W-1:0]   fs_q;
   logic [ADDR_W-1:0] rd_q;
   logic [REG_N-1:0]  pend_q, pend_d;

   assign dec_fs  = instr[FS_MSB:FS_LSB];
   assign dec_rd  = instr[RD_MSB:RD_LSB];
   assign dec_rs  = instr[RS_MSB:RS_LSB];
   assign dec_rt  = instr[RT_MSB:RT_LSB];
   assign rt_used = uses_rt(dec_fs);

   regfile_8x16 u_rf (
      .clk       (clk),
      .rst       (rst),
      .wb_en_i   (wb_en),
      .wb_addr_i (wb_addr),
      .wb_data_i (wb_data),
      .ra_a_i    (dec_rs),
      .ra_b_i    (dec_rt),
      .rd_a_o    (op_s),
      .rd_b_o    (op_t)
   );

   // A pending source only blocks if this cycle's write-back is not delivering it.
   assign hz_s = (dec_rs != '0) && pend_q[dec_rs] && !(wb_en && (wb_addr == dec_rs));
   assign hz_t = rt_used && (dec_rt != '0) && pend_q[dec_rt] && !(wb_en && (wb_addr == dec_rt));
   assign hazard = hz_s || hz_t;

   // Ready never looks at instr_valid, so upstream may wait on it without a loop.
   assign slot_free   = !out_valid_q || out_ready;
   assign instr_ready = slot_free && !hazard;
   assign accept      = instr_valid && instr_ready;

   // Scoreboard next state: clear on write-back first so a same-cycle set wins.
   always_comb begin
      pend_d = pend_q;
      if (wb_en) pend_d[wb_addr] = 1'b0;
      if (accept && (dec_rd != '0)) pend_d[dec_rd] = 1'b1;
      pend_d[0] = 1'b0;
   end

   // Output register and scoreboard; reset drops any held issue and all pending writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         ins_q       <= '0;
         int_q       <= '0;
         fs_q        <= '0;
         rd_q        <= '0;
         pend_q      <= '0;
      end else begin
         pend_q <= pend_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            ins_q       <= op_s;
            int_q       <= rt_used ? op_t : '0;
            fs_q        <= dec_fs;
            rd_q        <= dec_rd;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign inS       = ins_q;
   assign inT       = int_q;
   assign FS        = fs_q;
   assign rd_out    = rd_q;

endmodule
